ipbus_reg_slave: RTL and testbench

IPbus responder providing a small memory-mapped register bank: a read-only ID word, a read-only write counter, and NREGS-2 read/write control registers. It is the slave end of the same `ipb_in`/`ipb_out` bus that our IPbus master-side test classes drive: it decodes strobed word transactions, completes each one with a single-cycle `ipb_ack` or `ipb_err`, and exports the control registers to fabric logic. It supports programmable wait states, so the master's handshake-wait logic can be exercised.

---
 rtl/ipbus_reg_slave.sv | 123 ++++++++++++
 tb/tb_ipbus_reg_slave.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ipbus_reg_slave.sv
// IPbus slave exposing an ID word, a write counter and NREGS-2 control registers.
// Each strobed transaction ends in a one-cycle ack or err after WAIT_CYCLES wait states.
module ipbus_reg_slave #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          NREGS       = 8,
   parameter int          WAIT_CYCLES = 0,
   parameter logic [31:0] ID_VALUE    = 32'h1B05_0001
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [31:0]           ipb_addr,
   input  logic [31:0]           ipb_wdata,
   input  logic                  ipb_strobe,
   input  logic                  ipb_write,
   output logic [31:0]           ipb_rdata,
   output logic                  ipb_ack,
   output logic                  ipb_err,
   output logic [NREGS*32-1:0]   ctrl_regs
);

   localparam int IW = $clog2(NREGS);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t        state;
   logic [3:0]    wcnt;
   logic [31:0]   addr_q, wdata_q;
   logic          write_q;
   logic          resp_ok;
   logic [31:0]   resp_rdata;
   logic [31:0]   wcount;
   logic [31:0]   regs [NREGS];

   logic [31:0]   src_addr, dec_wdata, offset, dec_rdata;
   logic          dec_write, mapped, dec_ok, enter_resp;
   logic [IW-1:0] dec_idx;

   // Decode from the live bus when committing straight out of IDLE, else from the captured copy.
   always_comb begin
      // NOTE: every combinational output gets a value on every path so no latch is inferred.
      src_addr   = (state == IDLE) ? ipb_addr  : addr_q;
      dec_wdata  = (state == IDLE) ? ipb_wdata : wdata_q;
      dec_write  = (state == IDLE) ? ipb_write : write_q;
      offset     = src_addr - BASE_ADDR;
      dec_idx    = offset[IW-1:0];
      mapped     = (src_addr >= BASE_ADDR) && (offset < 32'(NREGS));
      dec_ok     = mapped && (!dec_write || offset >= 32'd2);
      dec_rdata  = '0;
      if (offset == 32'd0)      dec_rdata = ID_VALUE;
      else if (offset == 32'd1) dec_rdata = wcount;
      else if (mapped)          dec_rdata = regs[dec_idx];
      enter_resp = ipb_strobe &&
                   (((state == IDLE) && (WAIT_CYCLES == 0)) ||
                    ((state == WAIT) && (wcnt == 4'd1)));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         wcnt       <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         write_q    <= 1'b0;
         resp_ok    <= 1'b0;
         resp_rdata <= '0;
         wcount     <= '0;
         ipb_ack    <= 1'b0;
         ipb_err    <= 1'b0;
         ipb_rdata  <= '0;
         // NOTE: the register bank is architecturally visible, so it is cleared on reset like any flop.
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         ipb_ack   <= 1'b0;
         ipb_err   <= 1'b0;
         ipb_rdata <= '0;

         if (enter_resp) begin
            resp_ok    <= dec_ok;
            resp_rdata <= (dec_ok && !dec_write) ? dec_rdata : '0;
            if (dec_ok && dec_write) begin
               regs[dec_idx] <= dec_wdata;
               wcount        <= wcount + 32'd1;
            end
         end

         case (state)
            IDLE: if (ipb_strobe) begin
               addr_q  <= ipb_addr;
               wdata_q <= ipb_wdata;
               write_q <= ipb_write;
               if (WAIT_CYCLES == 0) begin
                  state <= RESP;
               end else begin
                  wcnt  <= 4'(WAIT_CYCLES);
                  state <= WAIT;
               end
            end
            WAIT: if (!ipb_strobe) begin
               state <= IDLE;
            end else begin
               wcnt <= wcnt - 4'd1;
               if (wcnt == 4'd1) state <= RESP;
            end
            RESP: begin
               ipb_ack   <= resp_ok;
               ipb_err   <= !resp_ok;
               ipb_rdata <= resp_rdata;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      ctrl_regs         = '0;
      ctrl_regs[31:0]   = ID_VALUE;
      ctrl_regs[63:32]  = wcount;
      for (int i = 2; i < NREGS; i++) ctrl_regs[32*i +: 32] = regs[i];
   end

endmodule

// File: tb/tb_ipbus_reg_slave.sv
// Bench for ipbus_reg_slave: a zero-wait instance and a three-wait instance at a non-zero base,
// checked every cycle against a transaction-level model plus literal spot checks.
module tb_ipbus_reg_slave;

   localparam int          NR = 8;
   localparam logic [31:0] ID = 32'h1B05_0001;
   localparam logic [31:0] B3 = 32'h0000_0100;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [31:0]      addr [2];
   logic [31:0]      wdata [2];
   logic [31:0]      rdata [2];
   logic             strobe [2];
   logic             write [2];
   logic             ack [2];
   logic             err [2];
   logic [NR*32-1:0] ctrl [2];

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] m_regs [2][NR];
   logic [31:0] m_wcount [2];
   logic        exp_ack [2];
   logic        exp_err [2];
   logic [31:0] exp_rdata [2];
   int          waits [2] = '{0, 3};
   logic [31:0] bases [2] = '{32'h0, B3};

   ipbus_reg_slave #(.BASE_ADDR(32'h0), .NREGS(NR), .WAIT_CYCLES(0), .ID_VALUE(ID)) dut0 (
      .clk(clk), .rst_n(rst_n), .ipb_addr(addr[0]), .ipb_wdata(wdata[0]),
      .ipb_strobe(strobe[0]), .ipb_write(write[0]), .ipb_rdata(rdata[0]),
      .ipb_ack(ack[0]), .ipb_err(err[0]), .ctrl_regs(ctrl[0]));

   ipbus_reg_slave #(.BASE_ADDR(B3), .NREGS(NR), .WAIT_CYCLES(3), .ID_VALUE(ID)) dut3 (
      .clk(clk), .rst_n(rst_n), .ipb_addr(addr[1]), .ipb_wdata(wdata[1]),
      .ipb_strobe(strobe[1]), .ipb_write(write[1]), .ipb_rdata(rdata[1]),
      .ipb_ack(ack[1]), .ipb_err(err[1]), .ctrl_regs(ctrl[1]));

   task automatic check(input string name, input logic [NR*32-1:0] act, input logic [NR*32-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_wcount[d]  = '0;
         exp_ack[d]   = 1'b0;
         exp_err[d]   = 1'b0;
         exp_rdata[d] = '0;
         for (int i = 0; i < NR; i++) m_regs[d][i] = '0;
      end
   endtask

   function automatic logic [NR*32-1:0] model_ctrl(input int d);
      logic [NR*32-1:0] v;
      for (int i = 0; i < NR; i++)
         v[32*i +: 32] = (i == 0) ? ID : (i == 1) ? m_wcount[d] : m_regs[d][i];
      return v;
   endfunction

   // Applies one access to the model; returns 1 for ack, 0 for err.
   function automatic bit model_access(input int d, input logic [31:0] a, input logic [31:0] wd,
                                       input bit wr, output logic [31:0] rd);
      longint off;
      off = longint'(a) - longint'(bases[d]);
      rd  = '0;
      if (off < 0 || off >= NR) return 1'b0;
      if (wr) begin
         if (off < 2) return 1'b0;
         m_regs[d][off] = wd;
         m_wcount[d]    = m_wcount[d] + 32'd1;
         return 1'b1;
      end
      rd = (off == 0) ? ID : (off == 1) ? m_wcount[d] : m_regs[d][off];
      return 1'b1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         exp_ack[d]   = 1'b0;
         exp_err[d]   = 1'b0;
         exp_rdata[d] = '0;
      end
   endtask

   // Drives one transaction and returns #1 after the edge that raises ack/err.
   task automatic txn(input int d, input logic [31:0] a, input logic [31:0] wd, input bit wr, input bit hold);
      logic [31:0] rd;
      bit          ok;
      time         t0;
      t0        = $time;
      addr[d]   = a;
      wdata[d]  = wd;
      write[d]  = wr;
      strobe[d] = 1'b1;
      tick();
      repeat (waits[d]) tick();
      ok = model_access(d, a, wd, wr, rd);
      tick();
      exp_ack[d]   = ok;
      exp_err[d]   = !ok;
      exp_rdata[d] = rd;
      if (!hold) strobe[d] = 1'b0;
      check($sformatf("latency_d%0d", d), 256'($time - t0), 256'(10 * (2 + waits[d])));
   endtask

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         check($sformatf("ack_d%0d", d),   256'(ack[d]),   256'(exp_ack[d]));
         check($sformatf("err_d%0d", d),   256'(err[d]),   256'(exp_err[d]));
         check($sformatf("rdata_d%0d", d), 256'(rdata[d]), 256'(exp_rdata[d]));
         check($sformatf("ctrl_d%0d", d),  ctrl[d],        model_ctrl(d));
      end
   end

   initial begin
      time t_prev;
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         addr[d] = '0; wdata[d] = '0; strobe[d] = 1'b0; write[d] = 1'b0;
      end
      model_reset();
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Reset values, then reads of ID, WCOUNT and an RW slot.
      check("rst_ctrl_slot1", 256'(ctrl[0][63:32]), 256'(0));
      txn(0, 32'd0, '0, 1'b0, 1'b0);
      check("rd_id", 256'(rdata[0]), 256'(ID));
      check("rd_id_err", 256'(err[0]), 256'(0));
      txn(0, 32'd1, '0, 1'b0, 1'b0);
      check("rd_wcount0", 256'({ack[0], rdata[0]}), 256'({1'b1, 32'd0}));
      txn(0, 32'd2, '0, 1'b0, 1'b0);
      check("rd_reg2_rst", 256'({ack[0], rdata[0]}), 256'({1'b1, 32'd0}));
      tick();

      // Writes to offsets 2..5, read-back and counter.
      txn(0, 32'd2, 32'hFFFF_FFFF, 1'b1, 1'b0);
      check("wr_ack_rdata0", 256'({ack[0], rdata[0]}), 256'({1'b1, 32'd0}));
      txn(0, 32'd3, 32'hCCCC_CCCC, 1'b1, 1'b0);
      txn(0, 32'd4, 32'hECEC_ECEC, 1'b1, 1'b0);
      txn(0, 32'd5, 32'hAAAA_AAAA, 1'b1, 1'b0);
      check("ctrl_slots", 256'(ctrl[0][191:64]),
            256'({32'hAAAA_AAAA, 32'hECEC_ECEC, 32'hCCCC_CCCC, 32'hFFFF_FFFF}));
      txn(0, 32'd3, '0, 1'b0, 1'b0);
      check("rd_reg3", 256'(rdata[0]), 256'(32'hCCCC_CCCC));
      txn(0, 32'd1, '0, 1'b0, 1'b0);
      check("rd_wcount4", 256'(rdata[0]), 256'(4));

      // Rejected accesses.
      txn(0, 32'd0, 32'h1111_1111, 1'b1, 1'b0);
      check("err_wr_id", 256'({err[0], ack[0], rdata[0]}), 256'({2'b10, 32'd0}));
      txn(0, 32'd1, 32'h2222_2222, 1'b1, 1'b0);
      check("err_wr_wcount", 256'({err[0], ack[0], rdata[0]}), 256'({2'b10, 32'd0}));
      txn(0, 32'(NR), '0, 1'b0, 1'b0);
      check("err_rd_unmapped", 256'({err[0], ack[0], rdata[0]}), 256'({2'b10, 32'd0}));
      check("id_wcount_kept", 256'(ctrl[0][63:0]), 256'({32'd4, ID}));

      // Back-to-back reads with strobe held: acks two cycles apart.
      tick();
      txn(0, 32'd2, '0, 1'b0, 1'b1);
      check("b2b_rd2", 256'(rdata[0]), 256'(32'hFFFF_FFFF));
      t_prev = $time;
      for (int i = 3; i <= 5; i++) begin
         txn(0, 32'(i), '0, 1'b0, i != 5);
         check($sformatf("b2b_space_%0d", i), 256'($time - t_prev), 256'(20));
         t_prev = $time;
      end
      check("b2b_rd5", 256'(rdata[0]), 256'(32'hAAAA_AAAA));

      // Counter wrap from a preset state.
      tick();
      force dut0.wcount = 32'hFFFF_FFFE;
      #1;
      release dut0.wcount;
      m_wcount[0] = 32'hFFFF_FFFE;
      tick();
      txn(0, 32'd6, 32'h0000_0006, 1'b1, 1'b0);
      check("wcount_max", 256'(ctrl[0][63:32]), 256'(32'hFFFF_FFFF));
      txn(0, 32'd7, 32'h0000_0007, 1'b1, 1'b0);
      txn(0, 32'd1, '0, 1'b0, 1'b0);
      check("wcount_wrap", 256'(rdata[0]), 256'(0));

      // Wait-state instance.
      tick();
      txn(1, B3 + 32'd3, 32'h5555_5555, 1'b1, 1'b0);
      check("w3_wr_ack", 256'(ack[1]), 256'(1));
      tick();
      addr[1] = B3 + 32'd3; wdata[1] = 32'h9999_9999; write[1] = 1'b1; strobe[1] = 1'b1;
      tick();
      tick();
      tick();
      strobe[1] = 1'b0;
      repeat (6) tick();
      txn(1, B3 + 32'd3, '0, 1'b0, 1'b0);
      check("w3_abort_kept", 256'(rdata[1]), 256'(32'h5555_5555));
      txn(1, B3 - 32'd1, '0, 1'b0, 1'b0);
      check("w3_below_base", 256'(err[1]), 256'(1));

      // Reset during the wait states of a write.
      tick();
      addr[1] = B3 + 32'd2; wdata[1] = 32'h7777_7777; write[1] = 1'b1; strobe[1] = 1'b1;
      tick();
      tick();
      rst_n = 1'b0;
      model_reset();
      strobe[1] = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      repeat (5) tick();
      txn(1, B3 + 32'd2, '0, 1'b0, 1'b0);
      check("rst_reg2", 256'({ack[1], rdata[1]}), 256'({1'b1, 32'd0}));
      txn(1, B3 + 32'd1, '0, 1'b0, 1'b0);
      check("rst_wcount", 256'({ack[1], rdata[1]}), 256'({1'b1, 32'd0}));
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
